// File: rtl/shift_cfg_loader_pkg.sv
// Shared types and default constants for the serial configuration loader.
package shift_cfg_pkg;

   localparam int DEFAULT_WORD_W     = 32;
   localparam int DEFAULT_FLUSH_BITS = 8;
   localparam int DEFAULT_DIV_W      = 8;
   localparam int DEFAULT_RST_CYCLES = 2;

   // Sequencer states: idle, shift clock low/high phases, trailing gap,
   // target reset pulse, and the single completion cycle.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOW  = 3'd1,
      HIGH = 3'd2,
      GAP  = 3'd3,
      RSTP = 3'd4,
      DONE = 3'd5
   } state_t;

endpackage

// File: rtl/shift_cfg_loader_phase_timer.sv
// Loadable down-counter timing one shift_clk phase of (load_val + 1) cycles.
module phase_timer #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   output logic             expire
);

   logic [DIV_W-1:0] count;

   // Reload at the start of a phase, otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   // Zero count marks the last cycle of the current phase.
   assign expire = (count == '0);

endmodule

// File: rtl/shift_cfg_loader.sv
// Sequencer that loads one config word into a bit-serial target: applies the
// clock selection, shifts FLUSH_BITS zeros then the word MSB first, and ends
// with a target reset pulse and a one-cycle done.
// Handshake: a request is taken on any rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high only in IDLE and DONE, and all
// request fields are captured on that edge only.
module shift_cfg_loader
   import shift_cfg_pkg::*;
#(
   parameter int WORD_W     = DEFAULT_WORD_W,
   parameter int FLUSH_BITS = DEFAULT_FLUSH_BITS,
   parameter int DIV_W      = DEFAULT_DIV_W,
   parameter int RST_CYCLES = DEFAULT_RST_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic [2:0]        cfg_clksel,
   input  logic [DIV_W-1:0]  half_period,
   output logic              tgt_shift_clk,
   output logic              tgt_shift_dta,
   output logic [2:0]        tgt_clksel,
   output logic              tgt_rst,
   output logic              busy,
   output logic              done,
   output state_t            fsm_state
);

   localparam int N     = FLUSH_BITS + WORD_W;
   localparam int CNT_W = $clog2(N + 1);
   localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   state_t           state;
   logic [N-1:0]     sreg;
   logic [N-1:0]     load_word;
   logic [CNT_W-1:0] bit_cnt;
   logic [DIV_W-1:0] h_lat;
   logic [RC_W-1:0]  rst_cnt;
   logic             accept;
   logic             phase_end;
   logic             timer_load;
   logic [DIV_W-1:0] timer_val;

   assign accept    = cfg_valid && cfg_ready;
   // Zero extension places the flush zeros ahead of the word MSB.
   assign load_word = N'(cfg_data);
   // A new phase starts on accept and at the end of every LOW or HIGH phase;
   // the first phase uses the live half_period since h_lat is not yet valid.
   assign timer_load = accept || (phase_end && (state == LOW || state == HIGH));
   assign timer_val  = accept ? half_period : h_lat;
   assign fsm_state  = state;

   phase_timer #(.DIV_W(DIV_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .expire   (phase_end)
   );

   // Main sequencer: all target-facing and handshake outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cfg_ready     <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         tgt_shift_clk <= 1'b0;
         tgt_shift_dta <= 1'b0;
         tgt_clksel    <= 3'b000;
         tgt_rst       <= 1'b0;
         sreg          <= '0;
         bit_cnt       <= '0;
         h_lat         <= '0;
         rst_cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state         <= LOW;
                  cfg_ready     <= 1'b0;
                  busy          <= 1'b1;
                  h_lat         <= half_period;
                  tgt_clksel    <= cfg_clksel;
                  tgt_shift_clk <= 1'b0;
                  tgt_shift_dta <= load_word[N-1];
                  sreg          <= load_word << 1;
                  bit_cnt       <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            LOW: begin
               if (phase_end) begin
                  state         <= HIGH;
                  tgt_shift_clk <= 1'b1;
               end
            end
            HIGH: begin
               if (phase_end) begin
                  tgt_shift_clk <= 1'b0;
                  if (bit_cnt < CNT_W'(N)) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
                  if (bit_cnt == CNT_W'(N - 1)) begin
                     state         <= GAP;
                     tgt_shift_dta <= 1'b0;
                  end else begin
                     // Data only moves on entry to LOW, keeping it stable
                     // around each rising edge of the shift clock.
                     state         <= LOW;
                     tgt_shift_dta <= sreg[N-1];
                     sreg          <= sreg << 1;
                  end
               end
            end
            GAP: begin
               if (phase_end) begin
                  state   <= RSTP;
                  tgt_rst <= 1'b1;
                  rst_cnt <= RC_W'(RST_CYCLES - 1);
               end
            end
            RSTP: begin
               if (rst_cnt == '0) begin
                  state     <= DONE;
                  tgt_rst   <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cfg_ready <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_cfg_loader.sv
// Bench for shift_cfg_loader: directed loads with hand-computed latencies,
// a scoreboard of expected shifted bit streams, and a monitor that rebuilds
// the target chain from tgt_shift_clk/tgt_shift_dta and checks on done.
module tb_shift_cfg_loader;
   import shift_cfg_pkg::*;

   localparam int WORD_W     = 32;
   localparam int FLUSH_BITS = 8;
   localparam int DIV_W      = 8;
   localparam int RST_CYCLES = 2;
   localparam int N          = FLUSH_BITS + WORD_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [WORD_W-1:0] cfg_data;
   logic [2:0]        cfg_clksel;
   logic [DIV_W-1:0]  half_period;
   logic              tgt_shift_clk;
   logic              tgt_shift_dta;
   logic [2:0]        tgt_clksel;
   logic              tgt_rst;
   logic              busy;
   logic              done;
   state_t            fsm_state;

   shift_cfg_loader #(
      .WORD_W(WORD_W), .FLUSH_BITS(FLUSH_BITS), .DIV_W(DIV_W), .RST_CYCLES(RST_CYCLES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_data      (cfg_data),
      .cfg_clksel    (cfg_clksel),
      .half_period   (half_period),
      .tgt_shift_clk (tgt_shift_clk),
      .tgt_shift_dta (tgt_shift_dta),
      .tgt_clksel    (tgt_clksel),
      .tgt_rst       (tgt_rst),
      .busy          (busy),
      .done          (done),
      .fsm_state     (fsm_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Result bookkeeping
   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard queues, one entry per issued request
   logic [N-1:0] exp_q[$];
   logic [2:0]   sel_q[$];
   int           hh_q[$];
   int           lat_q[$];

   // Monitor state
   logic         active = 1'b0;
   logic         sel_pending = 1'b0;
   logic         prev_sclk = 1'b0;
   logic [N-1:0] cap = '0;
   logic [N-1:0] cur_exp = '0;
   logic [2:0]   cur_sel = '0;
   int           cur_h = 0;
   int           cur_lat = 0;
   int           edge_cnt = 0;
   int           spacing_bad = 0;
   int           rst_w = 0;
   int           accept_cyc = 0;
   int           last_edge = 0;
   int           unexpected_done = 0;

   // Monitor: samples after the falling edge, rebuilds the target chain and
   // compares against the popped expectation whenever done pulses.
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         active      = 1'b0;
         sel_pending = 1'b0;
      end else begin
         if (active && tgt_shift_clk && !prev_sclk) begin
            cap = {cap[N-2:0], tgt_shift_dta};
            edge_cnt++;
            if (edge_cnt > 1 && (cyc - last_edge) != 2 * (cur_h + 1)) spacing_bad++;
            last_edge = cyc;
         end
         if (active && tgt_rst) rst_w++;
         if (sel_pending) begin
            check("tgt_clksel_after_accept", 64'(tgt_clksel), 64'(cur_sel));
            sel_pending = 1'b0;
         end
         if (done) begin
            if (!active) begin
               unexpected_done++;
            end else begin
               check("shifted_bits", 64'(cap), 64'(cur_exp));
               check("rising_edge_count", 64'(edge_cnt), 64'(N));
               check("edge_spacing_errors", 64'(spacing_bad), 64'(0));
               check("tgt_rst_width", 64'(rst_w), 64'(RST_CYCLES));
               check("done_latency", 64'(cyc - accept_cyc), 64'(cur_lat));
               check("busy_low_at_done", 64'(busy), 64'(0));
               active = 1'b0;
            end
         end
         if (cfg_valid && cfg_ready) begin
            if (exp_q.size() == 0) begin
               check("accept_without_request", 64'(1), 64'(0));
            end else begin
               cur_exp = exp_q.pop_front();
               cur_sel = sel_q.pop_front();
               cur_h   = hh_q.pop_front();
               cur_lat = lat_q.pop_front();
               active      = 1'b1;
               sel_pending = 1'b1;
               accept_cyc  = cyc + 1;
               cap         = '0;
               edge_cnt    = 0;
               spacing_bad = 0;
               rst_w       = 0;
            end
         end
      end
      prev_sclk = tgt_shift_clk;
   end

   // Driver: present one request and push its expectation
   task automatic push_exp(input logic [31:0] w, input logic [2:0] s, input int h, input int lat);
      exp_q.push_back({8'h00, w});
      sel_q.push_back(s);
      hh_q.push_back(h);
      lat_q.push_back(lat);
   endtask

   task automatic send(input logic [31:0] w, input logic [2:0] s, input int h, input int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!cfg_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_ready) check("ready_timeout", 64'(cfg_ready), 64'(1));
      cfg_valid   = 1'b1;
      cfg_data    = w;
      cfg_clksel  = s;
      half_period = DIV_W'(h);
      push_exp(w, s, h, lat);
      @(posedge clk);
      #1;
      cfg_valid   = 1'b0;
      cfg_data    = $urandom;
      cfg_clksel  = 3'($urandom_range(0, 7));
      half_period = DIV_W'($urandom_range(0, 255));
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!done && n < budget);
      check("done_within_budget", 64'(done), 64'(1));
   endtask

   // Main sequence
   initial begin
      int n;
      int activity;
      rst = 1'b1;
      cfg_valid = 1'b0;
      cfg_data = '0;
      cfg_clksel = '0;
      half_period = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #3;
      check("reset_cfg_ready", 64'(cfg_ready), 64'(1));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_shift_clk", 64'(tgt_shift_clk), 64'(0));
      check("reset_shift_dta", 64'(tgt_shift_dta), 64'(0));
      check("reset_clksel", 64'(tgt_clksel), 64'(0));
      check("reset_tgt_rst", 64'(tgt_rst), 64'(0));
      rst = 1'b0;

      activity = 0;
      repeat (10) begin
         @(negedge clk);
         #3;
         if (tgt_shift_clk || tgt_rst || done || busy) activity++;
      end
      check("idle_no_activity", 64'(activity), 64'(0));

      // All-ones word, fastest clock
      send(32'hFFFF_FFFF, 3'b001, 0, 83);
      wait_done(200);

      // Mixed pattern, H=3
      send(32'hA5C3_0F01, 3'b110, 3, 326);
      wait_done(500);

      // Back-to-back: second request accepted in the done cycle of the first,
      // with inputs toggling while the first load runs
      @(negedge clk);
      cfg_valid   = 1'b1;
      cfg_data    = 32'h1234_5678;
      cfg_clksel  = 3'b010;
      half_period = 8'd1;
      push_exp(32'h1234_5678, 3'b010, 1, 164);
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         if (!cfg_ready) begin
            cfg_data    = ~cfg_data;
            cfg_clksel  = ~cfg_clksel;
            half_period = ~half_period;
         end
         n++;
      end while (!cfg_ready && n < 400);
      check("b2b_ready_in_done_cycle", 64'(done), 64'(1));
      cfg_data    = 32'h8765_4321;
      cfg_clksel  = 3'b100;
      half_period = 8'd0;
      push_exp(32'h8765_4321, 3'b100, 0, 83);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      wait_done(200);

      // Abort at the 20th rising edge with H=1
      send(32'hDEAD_BEEF, 3'b011, 1, 164);
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (edge_cnt < 20 && n < 500);
      check("abort_reached_edge20", 64'(edge_cnt), 64'(20));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #3;
      check("abort_shift_clk", 64'(tgt_shift_clk), 64'(0));
      check("abort_shift_dta", 64'(tgt_shift_dta), 64'(0));
      check("abort_tgt_rst", 64'(tgt_rst), 64'(0));
      check("abort_clksel", 64'(tgt_clksel), 64'(0));
      check("abort_cfg_ready", 64'(cfg_ready), 64'(1));
      check("abort_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Fresh load after the abort, H=2
      send(32'h0F0F_F0F0, 3'b101, 2, 245);
      wait_done(500);

      // Slowest clock
      send(32'h8000_0000, 3'b111, 255, 20738);
      wait_done(21000);

      repeat (5) @(negedge clk);
      #3;
      check("no_spurious_done", 64'(unexpected_done), 64'(0));
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
